// File: rtl/mult_dispatcher.sv
// mult_dispatcher
//
// Operand dispatcher sitting in front of a sequential signed multiplier.
// The block does four things:
//   - buffers signed operand pairs in a DEPTH-entry FIFO;
//   - issues one pair at a time with a single-cycle mul_start pulse;
//   - waits for mul_done and captures the product;
//   - presents the product downstream on a valid/ready port with a wrapping
//     8-bit sequence tag.
// At most one multiplication is in flight, so results leave in FIFO order.
//
// Optional feature: define MULT_DISPATCH_TIMEOUT_EN to abort a job that
// spends TIMEOUT cycles in WAIT without mul_done. An aborted job still
// produces a result, with out_product=0 and out_err=1. Without the macro,
// WAIT lasts until mul_done arrives and out_err is tied low.
//
// Parameters:
//   WIDTH   operand width; the product is 2*WIDTH bits
//   DEPTH   operand FIFO entries (power of two, >= 2)
//   TIMEOUT maximum WAIT cycles before an abort (timeout build only)
//
// Ports:
//   clk, rst          clock and synchronous active-high reset. The
//                     multiplier's rst_n is expected to be driven from ~rst.
//   in_valid/in_ready upstream handshake; in_ready means the FIFO is not full
//   in_a, in_b        signed operand pair
//   out_valid/ready   downstream handshake for a held result
//   out_product       signed product
//   out_tag           sequence number of the result, modulo 256
//   out_err           result was aborted by timeout
//   mul_start         one-cycle start pulse to the multiplier
//   mul_multiplicand  operand to the multiplier, held until the next issue
//   mul_multiplier    operand to the multiplier, held until the next issue
//   mul_product       multiplier result
//   mul_done          multiplier completion
//   busy              FSM is not in IDLE
//   fifo_count        FIFO occupancy
module mult_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_a,
  input  logic signed [WIDTH-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_product,
  output logic [7:0]                out_tag,
  output logic                      out_err,
  output logic                      mul_start,
  output logic signed [WIDTH-1:0]   mul_multiplicand,
  output logic signed [WIDTH-1:0]   mul_multiplier,
  input  logic signed [2*WIDTH-1:0] mul_product,
  input  logic                      mul_done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_e;

  typedef struct packed {
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
  } pair_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("mult_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_e                    state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  pair_t                     fifo_mem_q [DEPTH];
  logic                      mul_start_q, mul_start_d;
  logic signed [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic signed [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [2*WIDTH-1:0] out_product_q, out_product_d;
  logic [7:0]                out_tag_q, out_tag_d;

  logic push;
  logic pop;

  // in_ready depends only on the registered count, so a push into a full
  // FIFO cannot happen even when a pop occurs in the same cycle.
  assign in_ready = (count_q != FULL_COUNT);
  assign push     = in_valid & in_ready;
  // The FIFO head is consumed on the IDLE -> ISSUE edge.
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

`ifdef MULT_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          out_err_q, out_err_d;
  logic          timed_out;

  // The counter holds 0 outside WAIT, so it starts from 0 on every entry.
  // Its value is the number of WAIT cycles already spent, so the abort
  // fires after exactly TIMEOUT cycles in WAIT.
  assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + TW'(1) : '0;
  assign timed_out  = (wait_cnt_q == WAIT_LAST);
  assign out_err    = out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      out_err_q  <= out_err_d;
    end
  end
`else
  assign out_err = 1'b0;
`endif

  // FIFO bookkeeping. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control FSM: next state and registered outputs.
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_tag_d     = out_tag_q;
`ifdef MULT_DISPATCH_TIMEOUT_EN
    out_err_d     = out_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d     = S_ISSUE;
          mul_start_d = 1'b1;
          mul_a_d     = fifo_mem_q[rd_ptr_q].a;
          mul_b_d     = fifo_mem_q[rd_ptr_q].b;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mul_done is only looked at here, so a stray or late done in any
        // other state has no effect.
        if (mul_done) begin
          state_d       = S_OUTPUT;
          out_valid_d   = 1'b1;
          out_product_d = mul_product;
`ifdef MULT_DISPATCH_TIMEOUT_EN
          out_err_d     = 1'b0;
        end else if (timed_out) begin
          state_d       = S_OUTPUT;
          out_valid_d   = 1'b1;
          out_product_d = '0;
          out_err_d     = 1'b1;
`endif
        end
      end
      S_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_tag_d   = out_tag_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand storage has no reset; the count and pointers define
  // which entries are live, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{a: in_a, b: in_b};
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign mul_start        = mul_start_q;
  assign mul_multiplicand = mul_a_q;
  assign mul_multiplier   = mul_b_q;
  assign out_valid        = out_valid_q;
  assign out_product      = out_product_q;
  assign out_tag          = out_tag_q;
  assign busy             = (state_q != S_IDLE);
  assign fifo_count       = count_q;

endmodule
